mul_seq_digit: RTL and testbench
================================

MUL_SEQ_DIGIT -- requirements
Module: mul_seq_digit

Interface
REQ-001 The block SHALL accept parameter W, default 8, meaning operand width in bits; legal values are even and 4..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have ports a and b, input, W bits each: unsigned operands.
REQ-007 The block SHALL have ports mul_a and mul_b, output, 2 bits each: registered digit operands driven to the external combinational 2x2 multiplier.
REQ-008 The block SHALL have port mul_p, input, 4 bits: 2x2 product returned combinationally from the external multiplier.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 The block SHALL have port prod, output, 2W bits: unsigned product a*b.
REQ-012 The block SHALL have port busy, output, 1 bit: high when the FSM is in RUN.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-015 On an edge with in_valid=1 and in_ready=1, the block SHALL do all of the following:
- latch a and b;
- clear the accumulator and set digit indices i=0 (a digit) and j=0 (b digit);
- load mul_a=a[1:0] and mul_b=b[1:0];
- enter RUN.
REQ-016 On each RUN edge, the block SHALL add the zero-extended value (mul_p << 2*(i+j)) to the 2W-bit accumulator, with no truncation loss for any legal operands.
REQ-017 The digit order SHALL be j inner and i outer, N=W/2 digits per operand; on each RUN edge the block SHALL advance the indices and load mul_a and mul_b with the next digit pair.
REQ-018 After the edge that accumulates pair (N-1,N-1), the block SHALL enter DONE and SHALL NOT issue further digit pairs; mul_a and mul_b SHALL then hold their value.
REQ-019 Latency SHALL be exactly N*N edges from the accept edge to out_valid=1 (16 edges for W=8).
REQ-020 In DONE, out_valid SHALL be 1 and prod SHALL equal the accumulator; prod SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1, the block SHALL return to IDLE on that edge and clear out_valid.
REQ-022 The block SHALL ignore in_valid while in RUN or DONE; latched operands SHALL NOT change.
REQ-023 Simultaneous out_ready=1 and in_valid=1 in DONE SHALL complete the result handoff only; the new operands are accepted no earlier than the following IDLE edge.
REQ-024 Zero operands SHALL still take the full N*N cycles; there is no early termination.
REQ-025 The block SHALL sample mul_p only on RUN edges and SHALL treat it as valid one cycle after mul_a and mul_b are registered.

Reset
REQ-026 While rst_n=0, the block SHALL hold the following outputs and state at these values:
- state=IDLE, in_ready=1, out_valid=0, busy=0;
- prod=0, mul_a=0, mul_b=0;
- accumulator and indices cleared.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL abort the operation; no partial result SHALL be presented after release.
REQ-028 After rst_n deasserts, the first edge SHALL be able to accept operands.

Verification
REQ-029 The bench SHALL model mul_p as mul_a*mul_b combinationally and SHALL cover these directed scenarios:
- V1: W=8, a=0xFF, b=0xFF accepted -> out_valid on 16th edge, prod=0xFE01.
- V2: a=0x12, b=0x34 -> prod=0x03A8 after 16 edges; a=0x00, b=0xAB -> prod=0x0000 after 16 edges.
- V3: out_ready held 0 for 10 cycles in DONE -> prod and out_valid stable; release -> IDLE next edge, in_ready=1.
- V4: in_valid pulsed with a=0x55 during RUN of a=0x03, b=0x07 -> prod=0x0015; the new operands are not captured.
- V5: rst_n pulsed low at RUN cycle 7 -> outputs at reset values immediately; the next operation a=0x0F, b=0x0F yields prod=0x00E1.
- V6: W=16, a=0xFFFF, b=0x0002 -> out_valid after 64 edges, prod=0x0001FFFE.

Source files
------------

// File: rtl/mul_seq_digit.sv
// mul_seq_digit
//   Sequential unsigned W x W multiplier. It splits both operands into 2-bit
//   digits and uses one external combinational 2x2 multiplier for each digit
//   pair, adding every shifted partial product into a 2W-bit accumulator.
//   For N = W/2 digits the result takes N*N cycles after the operands are
//   accepted.
//
// Ports
//   clk        : clock, rising edge active
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand pair offered
//   in_ready   : block can accept operands (state IDLE)
//   a, b       : unsigned operands, W bits each
//   mul_a/mul_b: registered 2-bit digits sent to the external multiplier
//   mul_p      : 4-bit product returned by the external multiplier
//   out_valid  : result available (state DONE)
//   out_ready  : consumer takes the result
//   prod       : unsigned product a*b, 2W bits
//   busy       : high while the multiplication is running
module mul_seq_digit #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [1:0]     mul_a,
  output logic [1:0]     mul_b,
  input  logic [3:0]     mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic           busy
);

  localparam int N  = W / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [2*W-1:0]  acc;
  logic [IW-1:0]   i;
  logic [IW-1:0]   j;
  logic [IW-1:0]   i_nxt;
  logic [IW-1:0]   j_nxt;
  logic            last;

  // Select digit k (bits 2k+1:2k) of an operand.
  function automatic logic [1:0] digit(input logic [W-1:0] v, input logic [IW-1:0] k);
    return v[2*int'(k) +: 2];
  endfunction

  // Place a 4-bit digit product at its weight 4^(di+dj) in the accumulator.
  // The largest shift is 2W-4, so the 4-bit product always fits.
  function automatic logic [2*W-1:0] partial(input logic [3:0] p,
                                             input logic [IW-1:0] di,
                                             input logic [IW-1:0] dj);
    logic [2*W-1:0] ext;
    ext = {{(2*W-4){1'b0}}, p};
    return ext << (2 * (int'(di) + int'(dj)));
  endfunction

  // Digit order: j (b digit) inner, i (a digit) outer.
  always_comb begin
    last  = (i == IW'(N-1)) && (j == IW'(N-1));
    i_nxt = i;
    j_nxt = j + IW'(1);
    if (j == IW'(N-1)) begin
      j_nxt = '0;
      i_nxt = i + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            mul_a    <= a[1:0];
            mul_b    <= b[1:0];
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // mul_p answers the digits registered on the previous edge.
          acc <= acc + partial(mul_p, i, j);
          if (last) begin
            // mul_a/mul_b keep the final pair; no further digits issued.
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            i     <= i_nxt;
            j     <= j_nxt;
            mul_a <= digit(a_q, i_nxt);
            mul_b <= digit(b_q, j_nxt);
          end
        end
        DONE: begin
          // A simultaneous in_valid is not taken here; acceptance needs IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign prod = acc;

endmodule

// File: tb/tb_mul_seq_digit.sv
module tb_mul_seq_digit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // W=8 instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [1:0]  mul_a;
  logic [1:0]  mul_b;
  logic [3:0]  mul_p;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] prod;
  logic        busy;

  // W=16 instance
  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic [1:0]  mul_a16;
  logic [1:0]  mul_b16;
  logic [3:0]  mul_p16;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic [31:0] prod16;
  logic        busy16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External 2x2 multipliers
  assign mul_p   = {2'b00, mul_a}   * {2'b00, mul_b};
  assign mul_p16 = {2'b00, mul_a16} * {2'b00, mul_b16};

  mul_seq_digit #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .busy(busy)
  );

  mul_seq_digit #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .mul_a(mul_a16), .mul_b(mul_b16), .mul_p(mul_p16),
    .out_valid(out_valid16), .out_ready(out_ready16), .prod(prod16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One W=8 multiplication. hold = cycles out_ready stays low in DONE,
  // inj = RUN cycle at which a stray in_valid is pulsed (-1 = none),
  // both = raise in_valid together with out_ready on the handoff edge.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input int hold, input int inj, input bit both);
    int k;
    logic [15:0] exp_p;
    logic [15:0] held;
    exp_p = 16'(av) * 16'(bv);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = av; b = bv;
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    k = 0;
    while (!out_valid && k < 100) begin
      if (k == 0) begin
        chk("busy_run", 32'(busy), 32'd1);
        chk("in_ready_run", 32'(in_ready), 32'd0);
      end
      if (k == inj) begin in_valid = 1'b1; a = 8'h55; end
      @(negedge clk);
      in_valid = 1'b0;
      k++;
    end
    chk("latency", 32'(k), 32'd16);
    chk("prod", 32'(prod), 32'(exp_p));
    chk("busy_done", 32'(busy), 32'd0);
    held = prod;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_prod", 32'(prod), 32'(held));
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    if (both) in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    // If the stray in_valid had been taken, in_ready would be low now.
    chk("release_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv);
    int k;
    @(negedge clk);
    in_valid16 = 1'b1; a16 = av; b16 = bv;
    @(negedge clk);
    in_valid16 = 1'b0;
    k = 0;
    while (!out_valid16 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("latency16", 32'(k), 32'd64);
    chk("prod16", prod16, 32'(av) * 32'(bv));
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    chk("release16", 32'(in_ready16), 32'd1);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prod", 32'(prod), 32'd0);
    chk("rst_mul", 32'({mul_a, mul_b}), 32'd0);
    rst_n = 1'b1;

    run8(8'hFF, 8'hFF, 0, -1, 1'b0);   // V1
    run8(8'h12, 8'h34, 0, -1, 1'b0);   // V2
    run8(8'h00, 8'hAB, 0, -1, 1'b0);
    run8(8'h5A, 8'hC3, 10, -1, 1'b0);  // V3
    run8(8'h03, 8'h07, 0, 4, 1'b0);    // V4
    run8(8'h9E, 8'h21, 2, -1, 1'b1);   // handoff with simultaneous in_valid

    // V5: reset in the middle of RUN
    @(negedge clk);
    in_valid = 1'b1; a = 8'hB7; b = 8'h6D;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_prod", 32'(prod), 32'd0);
    chk("midrst_mul", 32'({mul_a, mul_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h0F, 8'h0F, 0, -1, 1'b0);

    for (int n = 0; n < 20; n++)
      run8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 20)) - 3, 1'($urandom));

    // V6 and a few wide random cases
    run16(16'hFFFF, 16'h0002);
    run16(16'hFFFF, 16'hFFFF);
    for (int n = 0; n < 3; n++)
      run16(16'($urandom), 16'($urandom));

    k = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
